// File: rtl/debug_pipeline_controller_if.sv
// Debug-controller bus: serial command in, pipeline control, register read port, serial response out.
interface debug_pipeline_controller_if #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 5
);
  logic               rx_valid;
  logic [7:0]         rx_data;
  logic               prog_halt;
  logic               halt;
  logic [NB_ADDR-1:0] r_addr;
  logic [NB_DATA-1:0] r_data;
  logic               tx_valid;
  logic [7:0]         tx_data;
  logic               tx_ready;
  logic               busy;

  modport master (
    input  rx_valid, rx_data, prog_halt, r_data, tx_ready,
    output halt, r_addr, tx_valid, tx_data, busy
  );

  modport slave (
    output rx_valid, rx_data, prog_halt, r_data, tx_ready,
    input  halt, r_addr, tx_valid, tx_data, busy
  );
endinterface

// File: rtl/debug_pipeline_controller.sv
// Debug sequencer for the MIPS pipeline: decodes serial commands, gates the pipeline-wide halt,
// single-steps or free-runs, and streams the register file out LSB-first while frozen.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | pipeline frozen, waiting for a command byte
// RUN       | pipeline free-runs until the HALT instruction reaches ID
// STEP      | pipeline open for exactly one clock
// DUMP_RD   | latch register r_addr into the shift register
// DUMP_TX   | send the latched register one byte per handshake
// RESP      | hold the one-byte response until accepted
module debug_pipeline_controller #(
  parameter int         NB_DATA  = 32,
  parameter int         NB_ADDR  = 5,
  parameter int         NUM_REGS = 32,
  parameter logic [7:0] CMD_RUN  = 8'h01,
  parameter logic [7:0] CMD_STEP = 8'h02,
  parameter logic [7:0] CMD_DUMP = 8'h03
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  debug_pipeline_controller_if.master bus
);
  localparam int NB_BYTES = NB_DATA / 8;
  localparam int IDX_W    = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NB_BYTES - 1);
  localparam logic [NB_ADDR-1:0] LAST_REG = NB_ADDR'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_STEP, S_DUMP_RD, S_DUMP_TX, S_RESP
  } state_t;

  state_t             state, state_nxt;
  logic [NB_ADDR-1:0] r_addr, r_addr_nxt;
  logic [NB_DATA-1:0] shift, shift_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [7:0]         resp, resp_nxt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state  <= S_IDLE;
      r_addr <= '0;
      shift  <= '0;
      idx    <= '0;
      resp   <= '0;
    end else begin
      state  <= state_nxt;
      r_addr <= r_addr_nxt;
      shift  <= shift_nxt;
      idx    <= idx_nxt;
      resp   <= resp_nxt;
    end
  end

  assign bus.r_addr = r_addr;
  assign bus.busy   = (state != S_IDLE);

  always_comb begin
    state_nxt    = state;
    r_addr_nxt   = r_addr;
    shift_nxt    = shift;
    idx_nxt      = idx;
    resp_nxt     = resp;
    bus.halt     = 1'b1;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    case (state)
      S_IDLE: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == CMD_RUN) begin
            state_nxt = S_RUN;
          end else if (bus.rx_data == CMD_STEP) begin
            state_nxt = S_STEP;
          end else if (bus.rx_data == CMD_DUMP) begin
            state_nxt  = S_DUMP_RD;
            r_addr_nxt = '0;
            idx_nxt    = '0;
          end else begin
            state_nxt = S_RESP;
            resp_nxt  = 8'hEE;
          end
        end
      end
      // HALT in ID freezes the pipeline in the same cycle so it never retires.
      S_RUN: begin
        if (bus.prog_halt) begin
          state_nxt = S_RESP;
          resp_nxt  = 8'hD0;
        end else begin
          bus.halt = 1'b0;
        end
      end
      S_STEP: begin
        bus.halt  = 1'b0;
        state_nxt = S_RESP;
        resp_nxt  = 8'hA5;
      end
      S_DUMP_RD: begin
        shift_nxt = bus.r_data;
        state_nxt = S_DUMP_TX;
      end
      S_DUMP_TX: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = shift[7:0];
        if (bus.tx_ready) begin
          shift_nxt = shift >> 8;
          idx_nxt   = idx + IDX_W'(1);
          if (idx == LAST_IDX) begin
            idx_nxt = '0;
            if (r_addr == LAST_REG) begin
              state_nxt = S_IDLE;
            end else begin
              r_addr_nxt = r_addr + NB_ADDR'(1);
              state_nxt  = S_DUMP_RD;
            end
          end
        end
      end
      S_RESP: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = resp;
        if (bus.tx_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_debug_pipeline_controller.sv
// Randomized bench for debug_pipeline_controller against a register-array / program-counter model.
module tb_debug_pipeline_controller;
  localparam logic [7:0] CMD_RUN  = 8'h01;
  localparam logic [7:0] CMD_STEP = 8'h02;
  localparam logic [7:0] CMD_DUMP = 8'h03;

  logic i_clk = 1'b0;
  logic i_reset;
  always #5 i_clk = ~i_clk;

  debug_pipeline_controller_if #(.NB_DATA(32), .NB_ADDR(5)) bus ();

  debug_pipeline_controller dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus.master)
  );

  // Pipeline model: PC advances by one instruction on every unfrozen clock; HALT sits at halt_pc.
  logic [31:0] regs [32];
  logic [31:0] pc;
  logic [31:0] halt_pc;
  always @(posedge i_clk) begin
    if (i_reset)        pc <= 32'd0;
    else if (!bus.halt) pc <= pc + 32'd4;
  end
  assign bus.prog_halt = (pc == halt_pc);
  assign bus.r_data    = regs[bus.r_addr];

  int n_cmp = 0;
  int n_mis = 0;
  logic [7:0] got_q [$];
  int halt_low;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge i_clk);
    i_reset = 1'b1;
    repeat (n) @(negedge i_clk);
    chk("rst_halt", {31'd0, bus.halt}, 32'd1);
    chk("rst_txv",  {31'd0, bus.tx_valid}, 32'd0);
    chk("rst_addr", {27'd0, bus.r_addr}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    i_reset = 1'b0;
  endtask

  task automatic do_cmd(input logic [7:0] cmd, input int n_bytes, input bit rand_rdy, input bit inject);
    bit done = 0;
    bit pend = 0;
    logic [7:0] pend_data = 8'h00;
    got_q.delete();
    halt_low = 0;
    @(negedge i_clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = cmd;
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      @(negedge i_clk);
      bus.rx_valid = inject && ($urandom_range(0, 3) == 0);
      bus.rx_data  = CMD_STEP;
      bus.tx_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pend) chk("tx_hold", {23'd0, bus.tx_valid, bus.tx_data}, {23'd0, 1'b1, pend_data});
      pend      = bus.tx_valid && !bus.tx_ready;
      pend_data = bus.tx_data;
      if (!bus.halt) halt_low++;
      if (bus.tx_valid && bus.tx_ready) begin
        got_q.push_back(bus.tx_data);
        if (got_q.size() == n_bytes) done = 1;
      end
    end
    @(negedge i_clk);
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b0;
    chk("cmd_done", {31'd0, done}, 32'd1);
    chk("idle_after", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic check_dump(input string tag);
    chk({tag, "_len"}, got_q.size(), 32'd128);
    if (got_q.size() == 128) begin
      for (int k = 0; k < 128; k++)
        chk($sformatf("%s[%0d]", tag, k), {24'd0, got_q[k]}, {24'd0, regs[k / 4][8 * (k % 4) +: 8]});
    end
    chk({tag, "_halt"}, halt_low, 32'd0);
  endtask

  initial begin
    logic [31:0] pc_before;
    int k;
    logic [7:0] b;
    i_reset      = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_ready = 1'b0;
    halt_pc      = 32'd20;
    for (int r = 0; r < 32; r++) regs[r] = 32'd0;

    do_reset(2);

    // Single step from reset: one open clock, A5, PC +4.
    do_cmd(CMD_STEP, 1, 1'b0, 1'b0);
    chk("step_open", halt_low, 32'd1);
    chk("step_resp", {24'd0, got_q[0]}, 32'h0000_00A5);
    chk("step_pc", pc, 32'd4);

    // Run to a randomly placed HALT (including HALT at the first instruction), then step onto it.
    for (int it = 0; it < 4; it++) begin
      k = (it == 0) ? 5 : ((it == 1) ? 0 : int'($urandom_range(0, 7)));
      halt_pc = 32'(4 * k);
      do_reset(2);
      do_cmd(CMD_RUN, 1, 1'b1, 1'b0);
      chk("run_open", halt_low, k);
      chk("run_resp", {24'd0, got_q[0]}, 32'h0000_00D0);
      chk("run_pc", pc, 32'(4 * k));
      do_cmd(CMD_STEP, 1, 1'b0, 1'b0);
      chk("step_halt_open", halt_low, 32'd1);
      chk("step_halt_pc", pc, 32'(4 * k + 4));
    end
    halt_pc = 32'hFFFF_FFF0;

    // Fixed-pattern dump.
    regs[1]  = 32'h1122_3344;
    regs[31] = 32'hDEAD_BEEF;
    do_cmd(CMD_DUMP, 128, 1'b0, 1'b0);
    check_dump("dump");
    if (got_q.size() == 128) begin
      chk("dump_b4", {24'd0, got_q[4]}, 32'h44);
      chk("dump_b7", {24'd0, got_q[7]}, 32'h11);
      chk("dump_b124", {24'd0, got_q[124]}, 32'hEF);
      chk("dump_b127", {24'd0, got_q[127]}, 32'hDE);
    end

    // Same dump under random backpressure with injected STEP commands.
    pc_before = pc;
    do_cmd(CMD_DUMP, 128, 1'b1, 1'b1);
    check_dump("bp_dump");
    chk("bp_pc", pc, pc_before);

    // Random register contents.
    for (int r = 0; r < 32; r++) regs[r] = $urandom;
    do_cmd(CMD_DUMP, 128, 1'b1, 1'b0);
    check_dump("rnd_dump");

    // Unknown commands.
    for (int it = 0; it < 4; it++) begin
      if (it == 0) b = 8'h7F;
      else begin
        b = 8'($urandom_range(4, 255));
        if (it == 1) b = 8'h00;
      end
      do_cmd(b, 1, 1'b1, 1'b0);
      chk("unk_resp", {24'd0, got_q[0]}, 32'h0000_00EE);
      chk("unk_open", halt_low, 32'd0);
    end

    // Reset in the middle of the dump, at register 10, then a fresh dump from r0.
    @(negedge i_clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = CMD_DUMP;
    bus.tx_ready = 1'b1;
    @(negedge i_clk);
    bus.rx_valid = 1'b0;
    for (int c = 0; c < 2000 && bus.r_addr != 5'd10; c++) @(negedge i_clk);
    chk("reach_r10", {27'd0, bus.r_addr}, 32'd10);
    i_reset = 1'b1;
    @(negedge i_clk);
    i_reset = 1'b0;
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_txv", {31'd0, bus.tx_valid}, 32'd0);
    chk("mid_rst_halt", {31'd0, bus.halt}, 32'd1);
    chk("mid_rst_addr", {27'd0, bus.r_addr}, 32'd0);
    bus.tx_ready = 1'b0;
    do_cmd(CMD_DUMP, 128, 1'b0, 1'b0);
    check_dump("re_dump");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
